// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register-file write port between writeback and a buffered long-latency unit
module rf_write_arbiter #(
    parameter int DATA_WIDTH   = 64,
    parameter int REG_ADDR_W   = 5,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                       i_clk,
    input  logic                       i_arst,
    input  logic                       i_wb_we,
    input  logic [REG_ADDR_W-1:0]      i_wb_rd_addr,
    input  logic [DATA_WIDTH-1:0]      i_wb_data,
    input  logic                       i_lu_valid,
    input  logic [REG_ADDR_W-1:0]      i_lu_rd_addr,
    input  logic [DATA_WIDTH-1:0]      i_lu_data,
    output logic                       o_lu_ready,
    output logic                       o_reg_we,
    output logic [REG_ADDR_W-1:0]      o_rd_addr,
    output logic [DATA_WIDTH-1:0]      o_rd_write_data,
    output logic                       o_wb_stall,
    output logic [2**REG_ADDR_W-1:0]   o_busy_mask
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
    logic [REG_ADDR_W-1:0] addr_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] data_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, idx;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [SC_W-1:0]       sc_q, sc_d;
    logic [REG_ADDR_W-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_data;
    logic [2**REG_ADDR_W-1:0] mask;
    logic wb_eff, empty, full, starve_hit, gnt_a, gnt_b, gnt_c, gnt_d, deq, enq;
    assign head_addr  = addr_q[rd_ptr_q];
    assign head_data  = data_q[rd_ptr_q];
    assign wb_eff     = i_wb_we && i_wb_rd_addr != '0;
    assign empty      = cnt_q == '0;
    assign full       = cnt_q == CNT_W'(FIFO_DEPTH);
    assign starve_hit = sc_q == SC_W'(STARVE_LIMIT);
    assign gnt_a      = !empty && starve_hit && wb_eff;
    assign gnt_b      = wb_eff && !gnt_a;
    assign gnt_c      = !empty && !wb_eff;
    assign gnt_d      = empty && !wb_eff && i_lu_valid;
    assign deq        = gnt_a || gnt_c;
    // Outputs are forced quiet while reset is held, even though the bypass path is combinational.
    assign o_lu_ready = i_arst && !full;
    assign enq        = i_lu_valid && o_lu_ready && !gnt_d;
    assign o_rd_addr       = gnt_b ? i_wb_rd_addr : gnt_d ? i_lu_rd_addr : head_addr;
    assign o_rd_write_data = gnt_b ? i_wb_data : gnt_d ? i_lu_data : head_data;
    assign o_reg_we   = i_arst && (gnt_b || (deq && head_addr != '0) || (gnt_d && i_lu_rd_addr != '0));
    assign o_wb_stall = i_arst && gnt_a;
    assign o_busy_mask = i_arst ? mask : '0;
    always_comb begin
        mask = '0;
        idx  = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            idx = rd_ptr_q + PTR_W'(i);
            if (CNT_W'(i) < cnt_q) mask[addr_q[idx]] = 1'b1;
        end
        mask[0] = 1'b0;
    end
    always_comb begin
        cnt_d    = cnt_q + CNT_W'(enq) - CNT_W'(deq);
        rd_ptr_d = deq ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d = enq ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        sc_d     = (empty || deq) ? '0 : (gnt_b && !starve_hit) ? sc_q + SC_W'(1) : sc_q;
    end
    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            cnt_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            sc_q     <= '0;
        end else begin
            cnt_q    <= cnt_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            sc_q     <= sc_d;
        end
    end
    always_ff @(posedge i_clk) begin
        if (enq) begin
            addr_q[wr_ptr_q] <= i_lu_rd_addr;
            data_q[wr_ptr_q] <= i_lu_data;
        end
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed vector table, reset corner sequence, and randomized queue-model comparison
module tb_rf_write_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic        arst, wb_we, lu_valid, lu_ready, reg_we, wb_stall;
    logic [4:0]  wb_addr, lu_addr, rd_addr;
    logic [63:0] wb_data, lu_data, wr_data;
    logic [31:0] busy_mask;
    int checks = 0, errors = 0;

    rf_write_arbiter dut (
        .i_clk(clk), .i_arst(arst),
        .i_wb_we(wb_we), .i_wb_rd_addr(wb_addr), .i_wb_data(wb_data),
        .i_lu_valid(lu_valid), .i_lu_rd_addr(lu_addr), .i_lu_data(lu_data),
        .o_lu_ready(lu_ready), .o_reg_we(reg_we), .o_rd_addr(rd_addr),
        .o_rd_write_data(wr_data), .o_wb_stall(wb_stall), .o_busy_mask(busy_mask)
    );

    typedef struct {
        logic we; logic [4:0] wa; logic [63:0] wd;
        logic lv; logic [4:0] la; logic [63:0] ld;
        logic e_we; logic [4:0] e_addr; logic [63:0] e_data;
        logic e_rdy; logic e_stall; logic [31:0] e_mask;
    } vec_t;
    typedef struct { logic [4:0] a; logic [63:0] d; } ent_t;
    vec_t vt[$];
    ent_t q[$];
    int sc;

    function automatic vec_t mk(logic we, logic [4:0] wa, logic [63:0] wd, logic lv, logic [4:0] la,
                                logic [63:0] ld, logic ewe, logic [4:0] ea, logic [63:0] ed,
                                logic er, logic es, logic [31:0] em);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.lv = lv; v.la = la; v.ld = ld;
        v.e_we = ewe; v.e_addr = ea; v.e_data = ed; v.e_rdy = er; v.e_stall = es; v.e_mask = em;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                         input logic lv, input logic [4:0] la, input logic [63:0] ld);
        wb_we = we; wb_addr = wa; wb_data = wd; lu_valid = lv; lu_addr = la; lu_data = ld;
    endtask

    task automatic compare(input int idx, input logic ewe, input logic [4:0] ea, input logic [63:0] ed,
                           input logic er, input logic es, input logic [31:0] em);
        chk("reg_we", idx, 64'(reg_we), 64'(ewe));
        chk("lu_ready", idx, 64'(lu_ready), 64'(er));
        chk("wb_stall", idx, 64'(wb_stall), 64'(es));
        chk("busy_mask", idx, 64'(busy_mask), 64'(em));
        if (ewe) begin
            chk("rd_addr", idx, 64'(rd_addr), 64'(ea));
            chk("wr_data", idx, wr_data, ed);
        end
    endtask

    // Reference: a queue of accepted results plus a starvation count, resolved by the priority rules.
    task automatic model_step(input int idx);
        logic wb_eff, emp, rdy, pop, byp, stall, ewe;
        logic [4:0] ea;
        logic [63:0] ed;
        logic [31:0] em;
        wb_eff = wb_we && wb_addr != 0;
        emp = q.size() == 0;
        rdy = q.size() < 2;
        pop = 0; byp = 0; stall = 0; ewe = 0; ea = 0; ed = 0; em = 0;
        if (!emp && sc == 4 && wb_eff) begin stall = 1; pop = 1; end
        else if (wb_eff) begin ewe = 1; ea = wb_addr; ed = wb_data; end
        else if (!emp) pop = 1;
        else if (lu_valid) byp = 1;
        if (pop) begin ewe = q[0].a != 0; ea = q[0].a; ed = q[0].d; end
        if (byp) begin ewe = lu_addr != 0; ea = lu_addr; ed = lu_data; end
        foreach (q[i]) if (q[i].a != 0) em[q[i].a] = 1'b1;
        compare(idx, ewe, ea, ed, rdy, stall, em);
        @(posedge clk);
        if (emp || pop) sc = 0;
        else if (wb_eff && sc < 4) sc++;
        if (pop) void'(q.pop_front());
        if (lu_valid && rdy && !byp) q.push_back('{a: lu_addr, d: lu_data});
        @(negedge clk);
    endtask

    initial begin
        arst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #3;
        compare(-1, 0, 0, 0, 0, 0, 0);
        @(negedge clk); @(negedge clk);
        arst = 1'b1;

        vt.push_back(mk(0,0,0,       0,0,0,        0,0,0,        1,0,0));
        vt.push_back(mk(0,0,0,       1,5,'hAA,     1,5,'hAA,     1,0,0));
        vt.push_back(mk(1,3,'h30,    1,7,'h70,     1,3,'h30,     1,0,0));
        vt.push_back(mk(1,3,'h31,    0,0,0,        1,3,'h31,     1,0,'h80));
        vt.push_back(mk(1,3,'h32,    0,0,0,        1,3,'h32,     1,0,'h80));
        vt.push_back(mk(1,3,'h33,    0,0,0,        1,3,'h33,     1,0,'h80));
        vt.push_back(mk(1,3,'h34,    0,0,0,        1,3,'h34,     1,0,'h80));
        vt.push_back(mk(1,3,'h35,    0,0,0,        1,7,'h70,     1,1,'h80));
        vt.push_back(mk(1,3,'h35,    0,0,0,        1,3,'h35,     1,0,0));
        vt.push_back(mk(1,3,'h36,    1,9,'h90,     1,3,'h36,     1,0,0));
        vt.push_back(mk(1,0,'hEE,    0,0,0,        1,9,'h90,     1,0,'h200));
        vt.push_back(mk(1,4,'h40,    1,10,'hA0,    1,4,'h40,     1,0,0));
        vt.push_back(mk(1,4,'h41,    1,11,'hB0,    1,4,'h41,     1,0,'h400));
        vt.push_back(mk(1,4,'h42,    1,12,'hC0,    1,4,'h42,     0,0,'hC00));
        vt.push_back(mk(0,0,0,       1,12,'hC0,    1,10,'hA0,    0,0,'hC00));
        vt.push_back(mk(0,0,0,       1,12,'hC0,    1,11,'hB0,    1,0,'h800));
        vt.push_back(mk(0,0,0,       0,0,0,        1,12,'hC0,    1,0,'h1000));
        vt.push_back(mk(0,0,0,       0,0,0,        0,0,0,        1,0,0));
        vt.push_back(mk(1,5,'h50,    1,0,'h0F,     1,5,'h50,     1,0,0));
        vt.push_back(mk(0,0,0,       0,0,0,        0,0,0,        1,0,0));
        vt.push_back(mk(0,0,0,       1,6,'h66,     1,6,'h66,     1,0,0));
        vt.push_back(mk(0,0,0,       1,0,'h1,      0,0,0,        1,0,0));
        foreach (vt[i]) begin
            drive(vt[i].we, vt[i].wa, vt[i].wd, vt[i].lv, vt[i].la, vt[i].ld);
            #4;
            compare(i, vt[i].e_we, vt[i].e_addr, vt[i].e_data, vt[i].e_rdy, vt[i].e_stall, vt[i].e_mask);
            @(posedge clk); @(negedge clk);
        end

        // Reset with two buffered entries: outputs drop at once, nothing stale survives release.
        drive(1, 3, 'h1, 1, 20, 'h201); @(posedge clk); @(negedge clk);
        drive(1, 3, 'h2, 1, 21, 'h211); @(posedge clk); @(negedge clk);
        drive(1, 3, 'h3, 1, 22, 'h221);
        #2;
        compare(100, 1, 3, 'h3, 0, 0, 32'h0030_0000);
        arst = 1'b0;
        #1;
        compare(101, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        arst = 1'b1;
        #4;
        compare(102, 0, 0, 0, 1, 0, 0);
        @(posedge clk); @(negedge clk);
        #4;
        compare(103, 0, 0, 0, 1, 0, 0);
        @(posedge clk); @(negedge clk);

        q.delete();
        sc = 0;
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), {$urandom, $urandom},
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), {$urandom, $urandom});
            if ($urandom_range(0, 7) == 0) wb_addr = 0;
            if ($urandom_range(0, 7) == 0) lu_addr = 0;
            #4;
            model_step(200 + n);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Shares the single register-file write port (port 3) between the pipeline writeback stage and a long-latency unit (mul/div, cache refill).

Interface
REQ-001 Parameter DATA_WIDTH, default 64, width of write data.
REQ-002 Parameter REG_ADDR_W, default 5, register address width.
REQ-003 Parameter FIFO_DEPTH, default 2, long-latency result buffer entries (power of 2, >=2).
REQ-004 Parameter STARVE_LIMIT, default 4, consecutive WB-won cycles tolerated while buffer non-empty.
REQ-005 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-006 i_clk  in  1  clock, all state updates on rising edge.
REQ-007 i_arst  in  1  asynchronous reset, active-low.
REQ-008 i_wb_we  in  1  writeback write request.
REQ-009 i_wb_rd_addr  in  REG_ADDR_W  writeback destination.
REQ-010 i_wb_data  in  DATA_WIDTH  writeback data.
REQ-011 i_lu_valid  in  1  long-latency result valid.
REQ-012 i_lu_rd_addr  in  REG_ADDR_W  long-latency destination.
REQ-013 i_lu_data  in  DATA_WIDTH  long-latency data.
REQ-014 o_lu_ready  out  1  long-latency result accepted this cycle when high with i_lu_valid.
REQ-015 o_reg_we  out  1  register file write enable.
REQ-016 o_rd_addr  out  REG_ADDR_W  register file write address.
REQ-017 o_rd_write_data  out  DATA_WIDTH  register file write data.
REQ-018 o_wb_stall  out  1  writeback denied this cycle; pipeline holds WB stage contents.
REQ-019 o_busy_mask  out  2**REG_ADDR_W  bit n set when a buffered entry targets register n (bit 0 always 0).

Function
REQ-020 wb_eff = i_wb_we and i_wb_rd_addr != 0; x0 writes never reach the port.
REQ-021 Grant priority per cycle: (a) buffer head if non-empty and starve_cnt == STARVE_LIMIT and wb_eff; (b) WB if wb_eff; (c) buffer head if non-empty; (d) LU bypass if i_lu_valid and buffer empty; else no write.
REQ-022 Grant outputs are combinational in the same cycle; o_reg_we = 1 only for a grant whose address != 0.
REQ-023 o_wb_stall = 1 exactly in case (a); WB is not written in that cycle.
REQ-024 o_lu_ready = 1 when buffer count < FIFO_DEPTH; no same-cycle dequeue credit when full.
REQ-025 LU handshake (valid and ready) not taking the bypass enqueues {addr,data} at tail.
REQ-026 Head dequeues on grant (a) or (c); simultaneous enqueue and dequeue keeps count unchanged.
REQ-027 Buffered entries with address 0 dequeue without asserting o_reg_we.
REQ-028 LU results are written strictly in acceptance order; bypass only when buffer empty.
REQ-029 starve_cnt increments (saturating at STARVE_LIMIT) when buffer non-empty and WB granted; clears on any head dequeue or when buffer empty.
REQ-030 o_busy_mask is the OR of one-hot decodes of all valid entries' addresses; duplicates allowed.
REQ-031 Pointers wrap modulo FIFO_DEPTH; count width holds 0..FIFO_DEPTH.

Reset
REQ-032 While i_arst = 0: buffer emptied, starve_cnt = 0, o_reg_we = 0, o_lu_ready = 0, o_wb_stall = 0, o_busy_mask = 0.
REQ-033 Reset mid-operation discards buffered entries; first edge after release behaves as empty buffer.

Verification
REQ-034 Buffer empty, i_wb_we=0, i_lu_valid=1 rd=5 data=0xAA -> same cycle o_reg_we=1, o_rd_addr=5, data 0xAA, o_lu_ready=1.
REQ-035 WB writes rd=3 every cycle; LU pushes rd=7 -> o_busy_mask bit7=1; after 4 WB-won cycles o_wb_stall=1 for one cycle, rd=7 written, mask clears.
REQ-036 LU pushes 2 entries while WB busy -> o_lu_ready=0 on third; third valid held stalls until a dequeue.
REQ-037 WB rd=0 with buffer head rd=9 -> head written same cycle, no stall.
REQ-038 Reset asserted with 2 buffered entries -> all outputs 0 immediately; after release o_lu_ready=1, no stale write.
